// File: rtl/dram_line_ctrl.sv
// dram_line_ctrl: moves one cache line at a time between the bus/cache side
// and a synchronous-read RAM with one cycle of read latency. Words go out
// lowest offset first. Read data comes back word-serially, lined up with
// the RAM latency.
module dram_line_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32,
    parameter int WL2    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [AWIDTH-WL2-1:0]   req_line,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DWIDTH-1:0]       wr_data,
    output logic                    rd_valid,
    output logic [DWIDTH-1:0]       rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic [AWIDTH-1:0]       ram_addr,
    output logic [DWIDTH-1:0]       ram_din,
    output logic                    ram_we,
    input  logic [DWIDTH-1:0]       ram_dout
);

    localparam int WORDS = 1 << WL2;
    localparam int LAW   = AWIDTH - WL2;
    localparam logic [WL2-1:0] CNT_LAST = WL2'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t           state;
    logic [LAW-1:0]   line_q;
    logic [WL2-1:0]   cnt;

    // Sequencer: the line address is latched once per request, and the word
    // counter steps through the line. The counter is WL2 bits wide, so it
    // wraps inside the line and can never carry into the line address.
    // The read-return flags are registered one cycle behind each RD issue
    // so that they line up with the RAM's read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            line_q   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= (state == RD);
            rd_last  <= (state == RD) && (cnt == CNT_LAST);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_q <= req_line;
                        cnt    <= '0;
                        state  <= req_we ? WR : RD;
                    end
                end
                RD: begin
                    cnt <= cnt + WL2'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        cnt <= cnt + WL2'(1);
                        if (cnt == CNT_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshakes and RAM port signals decoded from the state register.
    // A write word is consumed in the same cycle it is offered in WR.
    always_comb begin
        req_ready = (state == IDLE);
        wr_ready  = (state == WR);
        done      = (state == DONE);
        ram_we    = (state == WR) && wr_valid;
        ram_addr  = {line_q, cnt};
        ram_din   = wr_data;
        rd_data   = ram_dout;
    end

endmodule

// File: tb/tb_dram_line_ctrl.sv
// Directed bench for dram_line_ctrl with a behavioural one-cycle-latency RAM.
module tb_dram_line_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_line;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done;
    logic [2:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:7];

    int passed = 0;
    int total  = 0;
    int beats  = 0;

    localparam logic [31:0] A = 32'hAAAA_0001;
    localparam logic [31:0] B = 32'hBBBB_0002;
    localparam logic [31:0] C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004;

    dram_line_ctrl #(.AWIDTH(3), .DWIDTH(32), .WL2(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_line  (req_line),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: registered read, write lands at the edge
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; drive there, check 1ns later
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_line = 2'd0;
        wr_valid = 1'b0; wr_data = 32'd0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[2] = A;
        mem[3] = B;

        // 1: reset two cycles, then idle; stray wr_valid is ignored
        step();
        step();
        reset = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h1234_5678;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_ram_addr", ram_addr, 0);

        // 2: line read of line 1 (accepted in this cycle T)
        wr_valid = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_line = 2'd1;
        step(); req_valid = 1'b0; #1;                        // T+1
        chk("rd_addr0", ram_addr, 2);
        chk("rd_we0", ram_we, 0);
        chk("rd_busy", req_ready, 0);
        chk("rd_v0", rd_valid, 0);
        step(); #1;                                          // T+2
        chk("rd_addr1", ram_addr, 3);
        chk("rd_v1", rd_valid, 1);
        chk("rd_data1", rd_data, A);
        chk("rd_last1", rd_last, 0);
        chk("rd_done1", done, 0);
        step(); #1;                                          // T+3
        chk("rd_v2", rd_valid, 1);
        chk("rd_data2", rd_data, B);
        chk("rd_last2", rd_last, 1);
        chk("rd_done2", done, 1);
        chk("rd_ready_done", req_ready, 0);
        step(); #1;                                          // T+4
        chk("rd_idle_v", rd_valid, 0);
        chk("rd_idle_done", done, 0);
        chk("rd_idle_ready", req_ready, 1);
        chk("rd_idle_addr", ram_addr, 2);

        // 3: write line 3 with a one-cycle gap between words
        req_valid = 1'b1; req_we = 1'b1; req_line = 2'd3;
        step(); req_valid = 1'b0; wr_valid = 1'b1; wr_data = C; #1;
        chk("wr_ready0", wr_ready, 1);
        chk("wr_we0", ram_we, 1);
        chk("wr_addr0", ram_addr, 6);
        chk("wr_din0", ram_din, C);
        step(); wr_valid = 1'b0; wr_data = 32'hDEAD_BEEF; #1;
        chk("wr_gap_we", ram_we, 0);
        chk("wr_gap_addr", ram_addr, 7);
        chk("wr_gap_ready", wr_ready, 1);
        step(); wr_valid = 1'b1; wr_data = D; #1;
        chk("wr_we1", ram_we, 1);
        chk("wr_addr1", ram_addr, 7);
        chk("wr_din1", ram_din, D);
        chk("wr_nodone", done, 0);
        step(); wr_valid = 1'b0; #1;
        chk("wr_done", done, 1);
        chk("wr_done_we", ram_we, 0);
        chk("wr_done_ready", wr_ready, 0);
        chk("wr_mem6", mem[6], C);
        chk("wr_mem7", mem[7], D);
        step(); #1;
        chk("wr_idle_ready", req_ready, 1);
        // read line 3 back
        req_valid = 1'b1; req_we = 1'b0; req_line = 2'd3;
        step(); req_valid = 1'b0; #1;
        step(); #1;
        chk("rbw_data0", rd_data, C);
        chk("rbw_v0", rd_valid, 1);
        step(); #1;
        chk("rbw_data1", rd_data, D);
        chk("rbw_last", rd_last, 1);
        step(); #1;

        // 4: back-to-back reads with req_valid held high
        beats = 0;
        req_valid = 1'b1; req_we = 1'b0; req_line = 2'd1;
        #1; beats += int'(rd_valid);                         // B0 accepted
        step(); #1; beats += int'(rd_valid);                 // B1
        chk("b2b_busy1", req_ready, 0);
        step(); #1; beats += int'(rd_valid);                 // B2
        step(); #1; beats += int'(rd_valid);                 // B3
        chk("b2b_done1", done, 1);
        chk("b2b_ready_in_done", req_ready, 0);
        step(); #1; beats += int'(rd_valid);                 // B4 second accepted
        chk("b2b_ready2", req_ready, 1);
        chk("b2b_gap_v", rd_valid, 0);
        step(); #1; beats += int'(rd_valid);                 // B5
        chk("b2b_addr2", ram_addr, 2);
        chk("b2b_gap_v2", rd_valid, 0);
        step(); req_valid = 1'b0; #1; beats += int'(rd_valid); // B6
        chk("b2b_data2a", rd_data, A);
        step(); #1; beats += int'(rd_valid);                 // B7
        chk("b2b_data2b", rd_data, B);
        chk("b2b_done2", done, 1);
        step(); #1; beats += int'(rd_valid);                 // B8
        chk("b2b_beats", beats, 4);
        chk("b2b_idle", req_ready, 1);

        // 5: reset in the middle of a read, after the first address issue
        req_valid = 1'b1; req_we = 1'b0; req_line = 2'd1;
        step(); req_valid = 1'b0; #1;
        chk("mid_addr0", ram_addr, 2);
        step(); reset = 1'b1; #1;
        step(); reset = 1'b0; #1;
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_rd_last", rd_last, 0);
        chk("mid_done", done, 0);
        chk("mid_ready", req_ready, 1);
        chk("mid_addr", ram_addr, 0);

        // 6: top line read wraps within the line only
        req_valid = 1'b1; req_we = 1'b0; req_line = 2'd3;
        step(); req_valid = 1'b0; #1;
        chk("top_addr0", ram_addr, 6);
        step(); #1;
        chk("top_addr1", ram_addr, 7);
        chk("top_data0", rd_data, C);
        step(); #1;
        chk("top_wrap_addr", ram_addr, 6);
        chk("top_data1", rd_data, D);
        chk("top_done", done, 1);
        step(); #1;
        chk("top_idle_addr", ram_addr, 6);
        chk("top_idle_ready", req_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
